// File: rtl/icap_multiboot_seq_pkg.sv
// -----------------------------------------------------------------------------
// mbt_pkg
// Shared definitions for the Spartan-6 ICAP MultiBoot sequencer:
//   - ICAP configuration words (sync, packet headers, REBOOT command, NOOP,
//     idle bus value)
//   - sequencer state encoding
//   - byte-wise bit-reversal helpers (ICAP expects each byte bit-swapped)
// -----------------------------------------------------------------------------
package mbt_pkg;

    localparam logic [15:0] SYNC_W0   = 16'hAA99;
    localparam logic [15:0] SYNC_W1   = 16'h5566;
    localparam logic [15:0] HDR_GEN1  = 16'h3261;
    localparam logic [15:0] HDR_GEN2  = 16'h3281;
    localparam logic [15:0] HDR_GEN3  = 16'h32A1;
    localparam logic [15:0] HDR_GEN4  = 16'h32C1;
    localparam logic [15:0] HDR_CMD   = 16'h30A1;
    localparam logic [15:0] CMD_IPROG = 16'h000E;
    localparam logic [15:0] NOOP_W    = 16'h2000;
    localparam logic [15:0] NULL_W    = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } mbt_state_t;

    // Mirror the bit order of one byte.
    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            r[k] = b[7-k];
        end
        return r;
    endfunction

    // ICAP data pins take each byte bit-reversed; the byte order is kept.
    function automatic logic [15:0] icap_swap(input logic [15:0] w);
        return {bitrev8(w[15:8]), bitrev8(w[7:0])};
    endfunction

endpackage

// File: rtl/icap_multiboot_seq_icap_s6_if.sv
// -----------------------------------------------------------------------------
// icap_s6_if
// Input register stage and wrapper around the ICAP_SPARTAN6 primitive.
// The word to write is bit-reversed per byte and registered together with the
// active-low CE/WRITE strobes, so the primitive always sees flop outputs.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset (CE/WRITE=1, I=FFFF)
//   ce_n_nxt  in   next value of CE and WRITE (active-low)
//   word_nxt  in   next configuration word, unreversed
//   busy      out  ICAP BUSY
//   dout      out  ICAP O data
//
// Build macro MBT_USE_UNISIM selects the real ICAP_SPARTAN6 primitive; without
// it a stand-in is used that never reports BUSY and loops the word being
// written back onto O (idle value FFFF), which keeps the block buildable
// without vendor libraries.
// -----------------------------------------------------------------------------
module icap_s6_if
    import mbt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_n_nxt,
    input  logic [15:0] word_nxt,
    output logic        busy,
    output logic [15:0] dout
);

    logic        ce_r;
    logic        write_r;
    logic [15:0] i_r;
    logic        icap_busy;
    logic [15:0] icap_o;

    // Register stage feeding the ICAP pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_r    <= 1'b1;
            write_r <= 1'b1;
            i_r     <= NULL_W;
        end else begin
            ce_r    <= ce_n_nxt;
            write_r <= ce_n_nxt;
            i_r     <= icap_swap(word_nxt);
        end
    end

`ifdef MBT_USE_UNISIM
    ICAP_SPARTAN6 u_icap (
        .BUSY  (icap_busy),
        .O     (icap_o),
        .CE    (ce_r),
        .CLK   (clk),
        .I     (i_r),
        .WRITE (write_r)
    );
`else
    assign icap_busy = 1'b0;
    assign icap_o    = (ce_r | write_r) ? NULL_W : i_r;
`endif

    assign busy = icap_busy;
    assign dout = icap_o;

endmodule

// File: rtl/icap_multiboot_seq.sv
// -----------------------------------------------------------------------------
// icap_multiboot_seq
// Spartan-6 ICAP MultiBoot sequencer. A reboot request latches a flash start
// address, writes it to GENERAL1/GENERAL2, then issues IPROG (REBOOT) followed
// by NOOP_COUNT NOOP words. ICAP BUSY stalls the word stream.
//
// Ports:
//   CLK             in   system clock
//   MBT_RESET       in   synchronous active-high reset
//   MBT_REBOOT      in   reboot request (accepted only in IDLE)
//   MBT_ADDR        in   target image address, latched on accept
//   MBT_BUSY        out  sequence in progress (WRITE or DONE)
//   MBT_DONE        out  one-cycle pulse after the last word
//   MBT_ICAP_STALL  out  mirrors ICAP BUSY
//   ICAP_DOUT       out  ICAP O data
//
// Build macro MBT_GOLDEN_EN inserts GENERAL3/GENERAL4 writes carrying
// GOLDEN_ADDR as the fallback image (4 extra words).
// -----------------------------------------------------------------------------
module icap_multiboot_seq
    import mbt_pkg::*;
#(
    parameter int          ADDR_W        = 24,
    parameter logic [7:0]  SPI_RD_OPCODE = 8'h0B,
    parameter int          NOOP_COUNT    = 4,
    parameter int unsigned GOLDEN_ADDR   = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              MBT_RESET,
    input  logic              MBT_REBOOT,
    input  logic [ADDR_W-1:0] MBT_ADDR,
    output logic              MBT_BUSY,
    output logic              MBT_DONE,
    output logic              MBT_ICAP_STALL,
    output logic [15:0]       ICAP_DOUT
);

`ifdef MBT_GOLDEN_EN
    localparam int          GOLD_WORDS = 4;
    localparam logic [23:0] GOLD_A     = GOLDEN_ADDR[23:0];
`else
    localparam int          GOLD_WORDS = 0;
`endif
    localparam int LEN     = 8 + NOOP_COUNT + GOLD_WORDS;
    localparam int CNT_W   = $clog2(LEN);
    localparam int CMD_IDX = 6 + GOLD_WORDS;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

    if (ADDR_W <= 16 || ADDR_W > 24 || NOOP_COUNT < 1 || NOOP_COUNT > 15 ||
        GOLDEN_ADDR > 32'h00FF_FFFF) begin : g_bad_param
        $error("icap_multiboot_seq: parameter out of range");
    end

    mbt_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [23:0]      addr_r;
    logic             busy_r;
    logic             done_r;
    logic             icap_busy;
    logic             ce_n_nxt;
    logic [15:0]      word_nxt;

    // Configuration word for a given table position.
    function automatic logic [15:0] word_at(input logic [CNT_W-1:0] idx,
                                            input logic [23:0]      a);
        logic [15:0] w;
        case (idx)
            CNT_W'(0):           w = SYNC_W0;
            CNT_W'(1):           w = SYNC_W1;
            CNT_W'(2):           w = HDR_GEN1;
            CNT_W'(3):           w = a[15:0];
            CNT_W'(4):           w = HDR_GEN2;
            CNT_W'(5):           w = {SPI_RD_OPCODE, a[23:16]};
`ifdef MBT_GOLDEN_EN
            CNT_W'(6):           w = HDR_GEN3;
            CNT_W'(7):           w = GOLD_A[15:0];
            CNT_W'(8):           w = HDR_GEN4;
            CNT_W'(9):           w = {SPI_RD_OPCODE, GOLD_A[23:16]};
`endif
            CNT_W'(CMD_IDX):     w = HDR_CMD;
            CNT_W'(CMD_IDX + 1): w = CMD_IPROG;
            default:             w = NOOP_W;
        endcase
        return w;
    endfunction

    // Next value for the ICAP register stage: the word that will sit on the
    // pins after this edge. On stall the current word is reloaded unchanged.
    always_comb begin
        ce_n_nxt = 1'b1;
        word_nxt = NULL_W;
        if (MBT_RESET) begin
            ce_n_nxt = 1'b1;
            word_nxt = NULL_W;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (MBT_REBOOT) begin
                        ce_n_nxt = 1'b0;
                        word_nxt = word_at(CNT_W'(0), addr_r);
                    end else begin
                        ce_n_nxt = 1'b1;
                        word_nxt = NULL_W;
                    end
                end
                ST_WRITE: begin
                    if (icap_busy) begin
                        ce_n_nxt = 1'b0;
                        word_nxt = word_at(cnt_r, addr_r);
                    end else if (cnt_r != LAST_IDX) begin
                        ce_n_nxt = 1'b0;
                        word_nxt = word_at(cnt_r + CNT_W'(1), addr_r);
                    end else begin
                        ce_n_nxt = 1'b1;
                        word_nxt = NULL_W;
                    end
                end
                default: begin
                    ce_n_nxt = 1'b1;
                    word_nxt = NULL_W;
                end
            endcase
        end
    end

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge CLK) begin
        if (MBT_RESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            addr_r  <= 24'h000000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (MBT_REBOOT) begin
                        state_r <= ST_WRITE;
                        cnt_r   <= '0;
                        addr_r  <= 24'(MBT_ADDR);
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (icap_busy) begin
                        cnt_r <= cnt_r;
                    end else if (cnt_r == LAST_IDX) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    icap_s6_if u_icap (
        .clk      (CLK),
        .rst      (MBT_RESET),
        .ce_n_nxt (ce_n_nxt),
        .word_nxt (word_nxt),
        .busy     (icap_busy),
        .dout     (ICAP_DOUT)
    );

    assign MBT_BUSY       = busy_r;
    assign MBT_DONE       = done_r;
    assign MBT_ICAP_STALL = icap_busy;

endmodule

// File: tb/tb_icap_multiboot_seq.sv
// -----------------------------------------------------------------------------
// tb_icap_multiboot_seq
// Directed bench for icap_multiboot_seq. Expected configuration words are
// queued when a request is issued and consumed as the ICAP pins present them;
// a word is retired only when BUSY was low on the edge that followed it.
// -----------------------------------------------------------------------------
module tb_icap_multiboot_seq;

    logic        clk = 1'b0;
    logic        mbt_reset;
    logic        mbt_reboot;
    logic [23:0] mbt_addr;
    logic        mbt_busy;
    logic        mbt_done;
    logic        mbt_icap_stall;
    logic [15:0] icap_dout;

    always #5 clk = ~clk;

    icap_multiboot_seq #(
        .ADDR_W        (24),
        .SPI_RD_OPCODE (8'h0B),
        .NOOP_COUNT    (4),
        .GOLDEN_ADDR   (32'h0000_0000)
    ) dut (
        .CLK            (clk),
        .MBT_RESET      (mbt_reset),
        .MBT_REBOOT     (mbt_reboot),
        .MBT_ADDR       (mbt_addr),
        .MBT_BUSY       (mbt_busy),
        .MBT_DONE       (mbt_done),
        .MBT_ICAP_STALL (mbt_icap_stall),
        .ICAP_DOUT      (icap_dout)
    );

`ifdef MBT_GOLDEN_EN
    localparam int LEN_EXP = 16;
`else
    localparam int LEN_EXP = 12;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          win_cnt;
    int          done_cnt;
    bit          prev_word;
    bit          busy_drv;

    function automatic logic [15:0] rev_bytes(input logic [15:0] w);
        logic [15:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k]     = w[7-k];
            r[8 + k] = w[15-k];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [23:0] a);
        exp_q.push_back(16'hAA99);
        exp_q.push_back(16'h5566);
        exp_q.push_back(16'h3261);
        exp_q.push_back(a[15:0]);
        exp_q.push_back(16'h3281);
        exp_q.push_back({8'h0B, a[23:16]});
`ifdef MBT_GOLDEN_EN
        exp_q.push_back(16'h32A1);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h32C1);
        exp_q.push_back(16'h0B00);
`endif
        exp_q.push_back(16'h30A1);
        exp_q.push_back(16'h000E);
        for (int k = 0; k < 4; k++) exp_q.push_back(16'h2000);
    endtask

    task automatic set_busy(input bit b);
        busy_drv = b;
        if (b) force dut.u_icap.icap_busy = 1'b1;
        else   release dut.u_icap.icap_busy;
    endtask

    // Advance to the next falling edge and check what the ICAP pins show.
    task automatic tick();
        @(negedge clk);
        if (prev_word && !busy_drv && exp_q.size() > 0) void'(exp_q.pop_front());
        prev_word = 1'b0;
        chk("stall_mirror", mbt_icap_stall, busy_drv);
        if (dut.u_icap.ce_r === 1'b0) begin
            win_cnt++;
            chk("write_n", dut.u_icap.write_r, 32'd0);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_word: observed %0h expected no write", dut.u_icap.i_r);
            end
            if (exp_q.size() != 0) begin
                chk("icap_i", dut.u_icap.i_r, rev_bytes(exp_q[0]));
                if (exp_q[0] == 16'h30A1) chk("bitrev_30A1", dut.u_icap.i_r, 32'h0C85);
            end
            prev_word = 1'b1;
        end
        if (mbt_done === 1'b1) done_cnt++;
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (mbt_busy === 1'b1 && n < budget);
        chk("idle_timeout", mbt_busy, 32'd0);
    endtask

    task automatic accept(input logic [23:0] a);
        win_cnt    = 0;
        done_cnt   = 0;
        mbt_addr   = a;
        mbt_reboot = 1'b1;
        push_seq(a);
        tick();
        mbt_reboot = 1'b0;
        chk("busy_after_accept", mbt_busy, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stalled;
        bit hit;
        int hold;
        int idle_cnt;

        mbt_reset  = 1'b1;
        mbt_reboot = 1'b0;
        mbt_addr   = 24'h000000;
        busy_drv   = 1'b0;
        prev_word  = 1'b0;
        win_cnt    = 0;
        done_cnt   = 0;
        tick();
        tick();
        chk("rst_ce",   dut.u_icap.ce_r,    32'd1);
        chk("rst_wr",   dut.u_icap.write_r, 32'd1);
        chk("rst_i",    dut.u_icap.i_r,     32'hFFFF);
        chk("rst_busy", mbt_busy,           32'd0);
        chk("rst_done", mbt_done,           32'd0);
        mbt_reset = 1'b0;
        tick();

        // Plain sequence, no stall.
        accept(24'h050000);
        run_idle(40);
        chk("t1_window", win_cnt, LEN_EXP);
        chk("t1_done",   done_cnt, 32'd1);
        chk("t1_drain",  exp_q.size(), 32'd0);

        // BUSY held for three edges while 0B05 is on the pins.
        accept(24'h050000);
        stalled = 1'b0;
        hold    = 0;
        repeat (60) begin
            if (mbt_busy !== 1'b1) break;
            if (hold > 0) begin
                hold--;
                if (hold == 0) set_busy(1'b0);
            end else if (!stalled && dut.u_icap.ce_r === 1'b0 &&
                         dut.u_icap.i_r === rev_bytes(16'h0B05)) begin
                stalled = 1'b1;
                hold    = 3;
                set_busy(1'b1);
            end
            tick();
        end
        if (busy_drv) set_busy(1'b0);
        chk("t2_stall_hit", stalled, 32'd1);
        chk("t2_idle",      mbt_busy, 32'd0);
        chk("t2_window",    win_cnt, LEN_EXP + 3);
        chk("t2_done",      done_cnt, 32'd1);
        chk("t2_drain",     exp_q.size(), 32'd0);

        // Reset while 30A1 is on the pins.
        accept(24'h050000);
        hit = 1'b0;
        repeat (20) begin
            if (dut.u_icap.ce_r === 1'b0 && dut.u_icap.i_r === rev_bytes(16'h30A1)) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("t3_hit", hit, 32'd1);
        mbt_reset = 1'b1;
        tick();
        mbt_reset = 1'b0;
        chk("t3_ce",   dut.u_icap.ce_r,    32'd1);
        chk("t3_wr",   dut.u_icap.write_r, 32'd1);
        chk("t3_i",    dut.u_icap.i_r,     32'hFFFF);
        chk("t3_busy", mbt_busy,           32'd0);
        chk("t3_done", mbt_done,           32'd0);
        exp_q.delete();
        prev_word = 1'b0;
        repeat (3) tick();
        chk("t3_no_done_pulse", done_cnt, 32'd0);
        chk("t3_still_idle",    mbt_busy, 32'd0);

        // Request together with reset is dropped, not queued.
        mbt_reset  = 1'b1;
        mbt_reboot = 1'b1;
        tick();
        mbt_reset  = 1'b0;
        mbt_reboot = 1'b0;
        chk("t4_busy", mbt_busy, 32'd0);
        chk("t4_ce",   dut.u_icap.ce_r, 32'd1);
        tick();
        chk("t4_busy_later", mbt_busy, 32'd0);
        chk("t4_ce_later",   dut.u_icap.ce_r, 32'd1);

        // Fresh request restarts from the sync word with a new address.
        accept(24'hABCDEF);
        run_idle(40);
        chk("t5_window", win_cnt, LEN_EXP);
        chk("t5_done",   done_cnt, 32'd1);
        chk("t5_drain",  exp_q.size(), 32'd0);

        // Request held: two back-to-back sequences, one IDLE cycle between.
        win_cnt    = 0;
        done_cnt   = 0;
        mbt_addr   = 24'h050000;
        mbt_reboot = 1'b1;
        push_seq(24'h050000);
        push_seq(24'h050000);
        idle_cnt = 0;
        repeat (27) begin
            tick();
            if (mbt_busy === 1'b0) idle_cnt++;
        end
        mbt_reboot = 1'b0;
        run_idle(40);
        chk("t6_idle_gap", idle_cnt, 32'd1);
        chk("t6_window",   win_cnt, 2 * LEN_EXP);
        chk("t6_done",     done_cnt, 32'd2);
        chk("t6_drain",    exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
